err_countdown_timer: RTL and testbench

- Seconds-resolution countdown timer that drives the 4-bit time_left field shown by the segment driver during the calculation-error state ("Err" plus a countdown).
- Started by the central FSM on entry to the error state; signals expiry so the FSM can return to operand entry.
- Contains a free-running prescaler that turns the system clock into a 1-second tick, plus a small IDLE/RUN state machine.

---
 rtl/err_countdown_timer_pkg.sv | 13 +
 rtl/err_countdown_timer_tick_prescaler.sv | 31 +++
 rtl/err_countdown_timer.sv | 87 ++++++++
 tb/tb_err_countdown_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/err_countdown_timer_pkg.sv
// Shared definitions for the error-state countdown timer and its neighbours
// (the central FSM and the segment driver).
package err_countdown_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_ERR_SEC = 10;
    localparam int SYS_CLK_HZ      = 100_000_000;

endpackage

// File: rtl/err_countdown_timer_tick_prescaler.sv
// Generic terminal-count divider: counts enabled cycles and pulses tick on the
// cycle the count wraps from TC-1 back to 0.
module tick_prescaler #(
    parameter int TC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TC > 1) ? $clog2(TC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    // clr wins over a terminal count landing in the same cycle.
    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/err_countdown_timer.sv
// Seconds countdown shown as "Err" plus time_left; pulses expired when the
// count reaches zero so the central FSM can return to operand entry.
module err_countdown_timer
    import err_countdown_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = SYS_CLK_HZ,
    parameter int DEFAULT_SEC = DEFAULT_ERR_SEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    input  logic [3:0] cfg_seconds,
    output logic [3:0] time_left,
    output logic       busy,
    output logic       sec_tick,
    output logic       expired
);

    state_t     state, next_state;
    logic [3:0] time_left_d;
    logic       sec_tick_d;
    logic       expired_d;
    logic [3:0] load_val;
    logic       pre_tick;

    assign load_val = (cfg_seconds == 4'd0) ? 4'(DEFAULT_SEC) : cfg_seconds;

    tick_prescaler #(
        .TC (CLK_FREQ_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN && !hold),
        .clr  (start || abort),
        .tick (pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            time_left <= 4'd0;
            busy      <= 1'b0;
            sec_tick  <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= next_state;
            time_left <= time_left_d;
            busy      <= (next_state == RUN);
            sec_tick  <= sec_tick_d;
            expired   <= expired_d;
        end
    end

    // Priority in RUN: abort, then restart, then the due tick.
    always_comb begin
        next_state  = state;
        time_left_d = time_left;
        sec_tick_d  = 1'b0;
        expired_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state  = RUN;
                    time_left_d = load_val;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (start) begin
                    time_left_d = load_val;
                end else if (pre_tick && time_left != 4'd0) begin
                    time_left_d = time_left - 4'd1;
                    sec_tick_d  = 1'b1;
                    if (time_left == 4'd1) begin
                        expired_d  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_err_countdown_timer.sv
// Bench for err_countdown_timer: directed latency checks plus a randomized run,
// all compared every cycle against an arithmetic model of the countdown.
module tb_err_countdown_timer;

    localparam int F   = 10;
    localparam int DEF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] cfg_seconds = 4'd0;
    logic [3:0] time_left;
    logic       busy;
    logic       sec_tick;
    logic       expired;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model state: run flag, loaded length, enabled cycles since load.
    logic       m_run = 1'b0;
    logic [3:0] m_left = 4'd0;
    int         m_n = 0;
    int         m_active = 0;
    logic       m_tick = 1'b0;
    logic       m_exp = 1'b0;

    err_countdown_timer #(
        .CLK_FREQ_HZ (F),
        .DEFAULT_SEC (DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .cfg_seconds (cfg_seconds),
        .time_left   (time_left),
        .busy        (busy),
        .sec_tick    (sec_tick),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // time_left = N - (enabled cycles / F); a tick on every multiple of F.
    always @(posedge clk or posedge rst) begin
        int na;
        int nl;
        if (rst) begin
            m_run <= 1'b0; m_left <= 4'd0; m_n <= 0; m_active <= 0;
            m_tick <= 1'b0; m_exp <= 1'b0;
        end else begin
            m_tick <= 1'b0;
            m_exp  <= 1'b0;
            if (m_run && abort) begin
                m_run <= 1'b0;
            end else if (start && !abort) begin
                m_run    <= 1'b1;
                m_n      <= (cfg_seconds == 4'd0) ? DEF : int'(cfg_seconds);
                m_left   <= (cfg_seconds == 4'd0) ? 4'(DEF) : cfg_seconds;
                m_active <= 0;
            end else if (m_run && !hold) begin
                na = m_active + 1;
                m_active <= na;
                if (na % F == 0) begin
                    nl = m_n - na / F;
                    m_tick <= 1'b1;
                    m_left <= 4'(nl);
                    if (nl == 0) begin
                        m_exp <= 1'b1;
                        m_run <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        check("time_left", int'(time_left), int'(m_left));
        check("busy",      int'(busy),      int'(m_run));
        check("sec_tick",  int'(sec_tick),  int'(m_tick));
        check("expired",   int'(expired),   int'(m_exp));
    end

    task automatic do_start(input logic [3:0] cfg, output int s);
        start = 1'b1;
        cfg_seconds = cfg;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_to(input int s, input int k);
        int guard = 0;
        while (cyc < s + k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_exp(input int s, input int budget, output int lat, output logic tk);
        lat = -1;
        tk = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (expired) begin
                lat = cyc - s;
                tk = sec_tick;
                break;
            end
        end
    endtask

    initial begin
        int s, s2, lat, cnt;
        logic tk;
        logic [3:0] frozen;

        @(negedge clk);
        @(negedge clk);
        check("reset time_left", int'(time_left), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic count of 3.
        do_start(4'd3, s);
        check("basic load", int'(time_left), 3);
        cnt = 0;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (sec_tick) begin
                cnt++;
                check("basic tick spacing", cyc - s, cnt * 10);
            end
            if (expired) begin
                lat = cyc - s;
                check("basic busy drop", int'(busy), 0);
            end
        end
        check("basic latency", lat, 30);
        check("basic tick count", cnt, 3);
        @(negedge clk);
        check("basic idle value", int'(time_left), 0);

        // Default length, then retrigger at +25 with 5.
        do_start(4'd0, s);
        check("default load", int'(time_left), 10);
        wait_to(s, 24);
        do_start(4'd5, s2);
        check("retrigger phase", s2 - s, 25);
        check("retrigger load", int'(time_left), 5);
        wait_exp(s2, 80, lat, tk);
        check("retrigger latency", lat, 50);

        // Abort at +15.
        do_start(4'd4, s);
        wait_to(s, 14);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort frozen", int'(time_left), 3);
        check("abort busy", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (expired) cnt++;
        end
        check("abort no expiry", cnt, 0);

        // start and abort together while idle.
        start = 1'b1; abort = 1'b1; cfg_seconds = 4'd6;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start+abort idle busy", int'(busy), 0);
        check("start+abort idle value", int'(time_left), 3);

        // Hold across +5..+11 samples.
        do_start(4'd2, s);
        wait_to(s, 4);
        hold = 1'b1;
        frozen = time_left;
        wait_to(s, 11);
        check("hold frozen", int'(time_left), int'(frozen));
        check("hold value", int'(time_left), 2);
        hold = 1'b0;
        wait_exp(s, 60, lat, tk);
        check("hold latency", lat, 27);

        // Asynchronous reset mid-count.
        do_start(4'd5, s);
        wait_to(s, 13);
        #2 rst = 1'b1;
        #1;
        check("async rst time_left", int'(time_left), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst tick", int'(sec_tick), 0);
        check("async rst expired", int'(expired), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sec_tick || expired) cnt++;
        end
        check("post reset quiet", cnt, 0);

        // Boundaries.
        do_start(4'd1, s);
        wait_exp(s, 40, lat, tk);
        check("one second latency", lat, 10);
        check("one second tick with expiry", int'(tk), 1);
        do_start(4'd15, s);
        wait_exp(s, 200, lat, tk);
        check("fifteen second latency", lat, 150);

        // Randomized traffic, checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            abort = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            cfg_seconds = 4'($urandom_range(0, 4));
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
